hazard_dest_tracker: RTL and testbench

- Producer side of the hazard-check interface: records the destination register and write-back enable of each instruction as it moves through the EXE, MEM and WB stages.
- Drives the EXE/MEM destination and enable signals that the hazard detection unit compares against ID-stage sources.
- Applies stall-bubble insertion, branch flush and memory-wait freeze, and exposes a pending-write scoreboard and a memory-wait watchdog.

---
 rtl/hazard_dest_tracker_pkg.sv | 28 ++
 rtl/hazard_dest_tracker_if.sv | 48 ++++
 rtl/hazard_dest_tracker_dest_stage_reg.sv | 54 +++++
 rtl/hazard_dest_tracker.sv | 157 +++++++++++++++
 tb/tb_hazard_dest_tracker.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_dest_tracker_pkg.sv
// hazard_dest_tracker_pkg
// Shared constants and types for the hazard destination tracker.
// Holds the register index width, the bubble encoding (Dest 0, WB_EN 0), the
// memory-wait FSM states and a one-hot helper used to build the pending mask.
package hazard_dest_tracker_pkg;

  // Register index width (16 architectural registers).
  localparam int unsigned REG_FILE_DEPTH = 4;
  localparam int unsigned NUM_REGS       = 1 << REG_FILE_DEPTH;

  typedef logic [REG_FILE_DEPTH-1:0] reg_idx_t;
  typedef logic [NUM_REGS-1:0]       reg_mask_t;

  // A bubble carries index 0 so no stale destination is ever visible.
  localparam reg_idx_t BUBBLE_DEST  = '0;
  localparam logic     BUBBLE_WB_EN = 1'b0;

  typedef enum logic [0:0] {
    StRun,
    StMemStall
  } mem_state_e;

  // One-hot of a destination, or zero when the entry does not write back.
  function automatic reg_mask_t dest_onehot(reg_idx_t dest, logic wb_en);
    return wb_en ? (reg_mask_t'(1) << dest) : '0;
  endfunction

endpackage

// File: rtl/hazard_dest_tracker_if.sv
// hazard_dest_tracker_if
// Bundles the ID-side request, pipeline controls and the per-stage destination
// outputs seen by the hazard detection unit.
//   master : pipeline controller (drives id_*, has_hazard, flush, mem_ready)
//   slave  : hazard_dest_tracker (drives id_accept, stage Dest/WB_EN, mask,
//            mem_wait, mem_timeout)
// Macro WB_TRACK_EN adds the WB_Dest / WB_WB_EN signals.
interface hazard_dest_tracker_if;
  import hazard_dest_tracker_pkg::*;

  logic      id_valid;
  logic      id_wb_en;
  reg_idx_t  id_dest;
  logic      has_hazard;
  logic      flush;
  logic      mem_ready;
  logic      id_accept;
  reg_idx_t  EXE_Dest;
  logic      EXE_WB_EN;
  reg_idx_t  MEM_Dest;
  logic      MEM_WB_EN;
  reg_mask_t pending_mask;
  logic      mem_wait;
  logic      mem_timeout;
`ifdef WB_TRACK_EN
  reg_idx_t  WB_Dest;
  logic      WB_WB_EN;
`endif

  modport master (
`ifdef WB_TRACK_EN
    input  WB_Dest, WB_WB_EN,
`endif
    output id_valid, id_wb_en, id_dest, has_hazard, flush, mem_ready,
    input  id_accept, EXE_Dest, EXE_WB_EN, MEM_Dest, MEM_WB_EN, pending_mask,
           mem_wait, mem_timeout
  );

  modport slave (
`ifdef WB_TRACK_EN
    output WB_Dest, WB_WB_EN,
`endif
    input  id_valid, id_wb_en, id_dest, has_hazard, flush, mem_ready,
    output id_accept, EXE_Dest, EXE_WB_EN, MEM_Dest, MEM_WB_EN, pending_mask,
           mem_wait, mem_timeout
  );

endinterface

// File: rtl/hazard_dest_tracker_dest_stage_reg.sv
// hazard_dest_tracker_dest_stage_reg
// One {Dest, WB_EN} pipeline stage register.
//   clk, rst         : clock, synchronous active-high reset (clears to bubble)
//   hold_i           : keep the current entry (highest priority after rst)
//   bubble_i         : load the bubble encoding
//   load_i           : load dest_i / wb_en_i
//   dest_o, wb_en_o  : registered entry
// With none of hold/bubble/load asserted the entry is kept.
module hazard_dest_tracker_dest_stage_reg
  import hazard_dest_tracker_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     hold_i,
  input  logic     bubble_i,
  input  logic     load_i,
  input  reg_idx_t dest_i,
  input  logic     wb_en_i,
  output reg_idx_t dest_o,
  output logic     wb_en_o
);

  reg_idx_t dest_q, dest_d;
  logic     wb_en_q, wb_en_d;

  always_comb begin
    dest_d  = dest_q;
    wb_en_d = wb_en_q;
    if (hold_i) begin
      dest_d  = dest_q;
      wb_en_d = wb_en_q;
    end else if (bubble_i) begin
      dest_d  = BUBBLE_DEST;
      wb_en_d = BUBBLE_WB_EN;
    end else if (load_i) begin
      dest_d  = dest_i;
      wb_en_d = wb_en_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dest_q  <= BUBBLE_DEST;
      wb_en_q <= BUBBLE_WB_EN;
    end else begin
      dest_q  <= dest_d;
      wb_en_q <= wb_en_d;
    end
  end

  assign dest_o  = dest_q;
  assign wb_en_o = wb_en_q;

endmodule

// File: rtl/hazard_dest_tracker.sv
// hazard_dest_tracker
// Producer side of the hazard-check interface. Tracks the destination register
// and write-back enable of the instructions in EXE and MEM (and WB when the
// WB_TRACK_EN macro is defined), applying stall bubbles, branch flushes and
// memory-wait freezes, and reports a pending-write mask plus a watchdog.
//   clk, rst : clock, synchronous active-high reset
//   bus      : hazard_dest_tracker_if.slave (ID request, controls, stage outputs)
// Parameter MEM_TIMEOUT: consecutive mem_ready-low edges before mem_timeout.
// Macro WB_TRACK_EN: adds a WB stage register, WB_Dest / WB_WB_EN, and covers
// WB in pending_mask.
module hazard_dest_tracker
  import hazard_dest_tracker_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input logic                  clk,
  input logic                  rst,
  hazard_dest_tracker_if.slave bus
);

  localparam int unsigned            CntWidth = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CntWidth-1:0]    CntMax   = CntWidth'(MEM_TIMEOUT);

  // Pipeline controls. A freeze outranks flush and hazard.
  logic freeze;
  logic kill;
  logic advance;

  always_comb begin
    freeze  = ~bus.mem_ready;
    advance = bus.mem_ready;
    kill    = bus.mem_ready & (bus.flush | bus.has_hazard);
  end

  // A flushed instruction is consumed (and dropped); a hazard holds it in ID.
  assign bus.id_accept = bus.mem_ready & (bus.flush | (~bus.has_hazard & bus.id_valid));

  // Stage registers
  reg_idx_t exe_dest, mem_dest;
  logic     exe_wb_en, mem_wb_en;

  hazard_dest_tracker_dest_stage_reg u_exe_stage (
    .clk      (clk),
    .rst      (rst),
    .hold_i   (freeze),
    .bubble_i (kill),
    .load_i   (advance),
    .dest_i   (bus.id_dest),
    .wb_en_i  (bus.id_wb_en & bus.id_valid),
    .dest_o   (exe_dest),
    .wb_en_o  (exe_wb_en)
  );

  hazard_dest_tracker_dest_stage_reg u_mem_stage (
    .clk      (clk),
    .rst      (rst),
    .hold_i   (freeze),
    .bubble_i (1'b0),
    .load_i   (advance),
    .dest_i   (exe_dest),
    .wb_en_i  (exe_wb_en),
    .dest_o   (mem_dest),
    .wb_en_o  (mem_wb_en)
  );

`ifdef WB_TRACK_EN
  reg_idx_t wb_dest;
  logic     wb_wb_en;

  hazard_dest_tracker_dest_stage_reg u_wb_stage (
    .clk      (clk),
    .rst      (rst),
    .hold_i   (freeze),
    .bubble_i (1'b0),
    .load_i   (advance),
    .dest_i   (mem_dest),
    .wb_en_i  (mem_wb_en),
    .dest_o   (wb_dest),
    .wb_en_o  (wb_wb_en)
  );

  assign bus.WB_Dest  = wb_dest;
  assign bus.WB_WB_EN = wb_wb_en;
`endif

  assign bus.EXE_Dest  = exe_dest;
  assign bus.EXE_WB_EN = exe_wb_en;
  assign bus.MEM_Dest  = mem_dest;
  assign bus.MEM_WB_EN = mem_wb_en;

  // Pending-write scoreboard; OR makes duplicate destinations collapse.
  reg_mask_t pending;

  always_comb begin
    pending = dest_onehot(exe_dest, exe_wb_en) | dest_onehot(mem_dest, mem_wb_en);
`ifdef WB_TRACK_EN
    pending = pending | dest_onehot(wb_dest, wb_wb_en);
`endif
  end

  assign bus.pending_mask = pending;

  // Memory-wait FSM
  mem_state_e state_q, state_d;
  logic       mem_wait;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:      if (!bus.mem_ready) state_d = StMemStall;
      StMemStall: if (bus.mem_ready)  state_d = StRun;
      default:    state_d = StRun;
    endcase
  end

  always_comb begin
    mem_wait = (state_q == StMemStall);
  end

  assign bus.mem_wait = mem_wait;

  // Watchdog: saturating count of consecutive mem_ready-low edges.
  logic [CntWidth-1:0] wait_cnt_q, wait_cnt_d;
  logic                timeout_q, timeout_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (bus.mem_ready) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != CntMax) begin
      wait_cnt_d = wait_cnt_q + CntWidth'(1);
    end
    // Sticky: set on the edge the count reaches the limit.
    timeout_d = timeout_q | (wait_cnt_d == CntMax);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.mem_timeout = timeout_q;

endmodule

// File: tb/tb_hazard_dest_tracker.sv
// tb_hazard_dest_tracker
// Self-checking bench for hazard_dest_tracker: directed vector table, watchdog
// and WB sequences, then randomized stimulus against a behavioural model.
module tb_hazard_dest_tracker;

  localparam int unsigned Timeout = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_dest_tracker_if bus ();

  hazard_dest_tracker #(
    .MEM_TIMEOUT (Timeout)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic       r, v, w, h, f, y;
    logic [3:0] d;
    logic       acc;
    logic [3:0] ed;
    logic       ew;
    logic [3:0] md;
    logic       mw;
    logic [15:0] mask;
    logic       wt;
  } vec_t;

  function automatic vec_t mk(logic r, logic v, logic w, logic h, logic f, logic y,
                              logic [3:0] d, logic acc, logic [3:0] ed, logic ew,
                              logic [3:0] md, logic mw, logic [15:0] mask, logic wt);
    vec_t t;
    t.r = r; t.v = v; t.w = w; t.h = h; t.f = f; t.y = y; t.d = d; t.acc = acc;
    t.ed = ed; t.ew = ew; t.md = md; t.mw = mw; t.mask = mask; t.wt = wt;
    return t;
  endfunction

  task automatic drive(input logic r, input logic v, input logic w, input logic h,
                       input logic f, input logic y, input logic [3:0] d);
    rst = r; bus.id_valid = v; bus.id_wb_en = w; bus.has_hazard = h;
    bus.flush = f; bus.mem_ready = y; bus.id_dest = d;
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0] m_dest[3];   // 0: EXE, 1: MEM, 2: WB
  logic       m_wb[3];
  int         m_low_run;
  logic       m_to;
  logic       m_wait;

  function automatic logic model_accept(logic v, logic h, logic f, logic y);
    if (!y) return 1'b0;
    if (f) return 1'b1;
    if (h) return 1'b0;
    return v;
  endfunction

  task automatic model_edge(input logic r, input logic v, input logic w, input logic h,
                            input logic f, input logic y, input logic [3:0] d);
    if (r) begin
      for (int i = 0; i < 3; i++) begin m_dest[i] = 0; m_wb[i] = 0; end
      m_low_run = 0; m_to = 0; m_wait = 0;
    end else if (!y) begin
      m_wait = 1;
      if (m_low_run < Timeout) m_low_run++;
      if (m_low_run == Timeout) m_to = 1;
    end else begin
      m_wait = 0;
      m_low_run = 0;
      m_dest[2] = m_dest[1]; m_wb[2] = m_wb[1];
      m_dest[1] = m_dest[0]; m_wb[1] = m_wb[0];
      if (f || h) begin m_dest[0] = 0; m_wb[0] = 0; end
      else begin m_dest[0] = d; m_wb[0] = w & v; end
    end
  endtask

  function automatic logic [15:0] model_mask();
    logic [15:0] m = '0;
`ifdef WB_TRACK_EN
    for (int i = 0; i < 3; i++) if (m_wb[i]) m[m_dest[i]] = 1'b1;
`else
    for (int i = 0; i < 2; i++) if (m_wb[i]) m[m_dest[i]] = 1'b1;
`endif
    return m;
  endfunction

  vec_t vecs[$];

  initial begin
    drive(1, 0, 0, 0, 0, 1, 0);

    //             r  v  w  h  f  y  d   acc ed ew md mw mask     wt
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0,  0,  0, 0, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 5,  1,  5, 1, 0, 0, 16'h0020, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0,  0,  0, 0, 5, 1, 16'h0020, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0,  0,  0, 0, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 1, 3,  0,  0, 0, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 3,  1,  3, 1, 0, 0, 16'h0008, 0));
    vecs.push_back(mk(0, 1, 1, 0, 1, 1, 7,  1,  0, 0, 3, 1, 16'h0008, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0,  0,  0, 0, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 9,  1,  9, 1, 0, 0, 16'h0200, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 2,  1,  2, 1, 9, 1, 16'h0204, 0));
    // Freeze: entries hold; flush and hazard are ignored.
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 11, 0,  2, 1, 9, 1, 16'h0204, 1));
    vecs.push_back(mk(0, 1, 1, 0, 1, 0, 11, 0,  2, 1, 9, 1, 16'h0204, 1));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 11, 0,  2, 1, 9, 1, 16'h0204, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0,  0,  0, 0, 2, 1, 16'h0004, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0,  0,  0, 0, 0, 0, 16'h0000, 0));
    // Reset during a stall discards all entries.
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, 5,  1,  5, 1, 0, 0, 16'h0020, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0,  5, 1, 0, 0, 16'h0020, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0,  0, 0, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0,  0,  0, 0, 0, 0, 16'h0000, 0));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].r, vecs[i].v, vecs[i].w, vecs[i].h, vecs[i].f, vecs[i].y, vecs[i].d);
      #1;
      check($sformatf("vec%0d id_accept", i), 32'(bus.id_accept), 32'(vecs[i].acc));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d EXE_Dest", i), 32'(bus.EXE_Dest), 32'(vecs[i].ed));
      check($sformatf("vec%0d EXE_WB_EN", i), 32'(bus.EXE_WB_EN), 32'(vecs[i].ew));
      check($sformatf("vec%0d MEM_Dest", i), 32'(bus.MEM_Dest), 32'(vecs[i].md));
      check($sformatf("vec%0d MEM_WB_EN", i), 32'(bus.MEM_WB_EN), 32'(vecs[i].mw));
      check($sformatf("vec%0d pending_mask", i), 32'(bus.pending_mask), 32'(vecs[i].mask));
      check($sformatf("vec%0d mem_wait", i), 32'(bus.mem_wait), 32'(vecs[i].wt));
      check($sformatf("vec%0d mem_timeout", i), 32'(bus.mem_timeout), 32'd0);
    end

    // ---------------- watchdog sequence ----------------
    for (int k = 1; k <= Timeout; k++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      if (k == Timeout - 1) check("wdog before limit", 32'(bus.mem_timeout), 32'd0);
    end
    check("wdog at limit", 32'(bus.mem_timeout), 32'd1);
    check("wdog mem_wait", 32'(bus.mem_wait), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 1, 0);
      @(posedge clk);
      #1;
    end
    check("wdog sticky", 32'(bus.mem_timeout), 32'd1);
    check("wdog wait cleared", 32'(bus.mem_wait), 32'd0);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 1, 0);
    @(posedge clk);
    #1;
    check("wdog rst clears", 32'(bus.mem_timeout), 32'd0);

`ifdef WB_TRACK_EN
    // ---------------- WB tracking sequence ----------------
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) drive(0, 1, 1, 0, 0, 1, 4);
      else drive(0, 0, 0, 0, 0, 1, 0);
      @(posedge clk);
      #1;
      check($sformatf("wb edge%0d mask", k), 32'(bus.pending_mask), 32'h0010);
    end
    check("wb WB_Dest", 32'(bus.WB_Dest), 32'd4);
    check("wb WB_WB_EN", 32'(bus.WB_WB_EN), 32'd1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1, 0);
    @(posedge clk);
    #1;
    check("wb drained mask", 32'(bus.pending_mask), 32'h0000);
`endif

    // ---------------- randomized vs model ----------------
    for (int c = 0; c < 2000; c++) begin
      logic r, v, w, h, f, y;
      logic [3:0] d;
      r = (c == 0) || ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 3) != 0);
      w = ($urandom_range(0, 3) != 0);
      h = ($urandom_range(0, 5) == 0);
      f = ($urandom_range(0, 7) == 0);
      y = ($urandom_range(0, 3) != 0);
      d = 4'($urandom_range(0, 15));
      // One long memory wait to reach the watchdog limit.
      if (c >= 1000 && c < 1000 + Timeout + 6) begin r = 0; y = 0; end
      @(negedge clk);
      drive(r, v, w, h, f, y, d);
      #1;
      check("rnd id_accept", 32'(bus.id_accept), 32'(model_accept(v, h, f, y)));
      @(posedge clk);
      model_edge(r, v, w, h, f, y, d);
      #1;
      check("rnd EXE_Dest", 32'(bus.EXE_Dest), 32'(m_dest[0]));
      check("rnd EXE_WB_EN", 32'(bus.EXE_WB_EN), 32'(m_wb[0]));
      check("rnd MEM_Dest", 32'(bus.MEM_Dest), 32'(m_dest[1]));
      check("rnd MEM_WB_EN", 32'(bus.MEM_WB_EN), 32'(m_wb[1]));
`ifdef WB_TRACK_EN
      check("rnd WB_Dest", 32'(bus.WB_Dest), 32'(m_dest[2]));
      check("rnd WB_WB_EN", 32'(bus.WB_WB_EN), 32'(m_wb[2]));
`endif
      check("rnd pending_mask", 32'(bus.pending_mask), 32'(model_mask()));
      check("rnd mem_wait", 32'(bus.mem_wait), 32'(m_wait));
      check("rnd mem_timeout", 32'(bus.mem_timeout), 32'(m_to));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
